// File: rtl/nv_nvdla_sdp_wdma_pack_pkg.sv
// Shared SDP constants and small mask helpers used by the write-path packer.
package nv_nvdla_sdp_wdma_pack_pkg;

  localparam int SDP_ATOM_W = 256;
  localparam int SDP_ATOMS  = 4;

  // Legal wide-word / DMA-beat width ratios
  function automatic bit ratio_is_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4);
  endfunction

  // Number of mask bits set; masks narrower than 32 bits are zero-extended by the caller
  function automatic int mask_ones(input logic [31:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(mask[i]);
    end
    return n;
  endfunction

  // A legal mask is a run of ones starting at bit 0 (including all-zero)
  function automatic bit mask_is_contig(input logic [31:0] mask);
    return (mask & (mask + 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_wdma_pack.sv
// SDP write-path width-down packer: splits one wide masked word into
// narrow DMA beats, holding the word until its last valid beat leaves.
module nv_nvdla_sdp_wdma_pack
  import nv_nvdla_sdp_wdma_pack_pkg::*;
#(
  parameter int  ATOM_W     = SDP_ATOM_W,
  parameter int  ATOMS      = SDP_ATOMS,
  parameter int  RATIO      = 2,
  localparam int BEAT_ATOMS = ATOMS / RATIO,
  localparam int IN_W       = ATOMS * ATOM_W + ATOMS,
  localparam int OUT_W      = BEAT_ATOMS * ATOM_W + BEAT_ATOMS
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             inp_pvld,
  output logic             inp_prdy,
  input  logic [IN_W-1:0]  inp_data,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int SEG_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BEAT_W = BEAT_ATOMS * ATOM_W;

  logic                    hold_vld;
  logic [ATOMS-1:0]        hold_mask;
  logic [ATOMS*ATOM_W-1:0] hold_data;
  logic [SEG_W-1:0]        seg_cnt;

  logic [ATOMS-1:0] inp_mask;
  logic             in_fire;
  logic             in_load;
  logic             out_fire;
  logic             is_last;
  int               beat_n;

  assign inp_mask = inp_data[IN_W-1 -: ATOMS];
  assign in_fire  = inp_pvld & inp_prdy;
  // Zero-mask words are consumed without occupying the holding register
  assign in_load  = in_fire & (|inp_mask);
  assign out_pvld = hold_vld;
  assign out_fire = out_pvld & out_prdy;
  assign is_last  = out_fire & out_last;
  // A new word may load in the same cycle the last beat leaves
  assign inp_prdy = ~hold_vld | is_last;

  // Beat count of the held word and last-beat decode
  always_comb begin
    beat_n   = (mask_ones(32'(hold_mask)) + BEAT_ATOMS - 1) / BEAT_ATOMS;
    out_last = (int'(seg_cnt) == beat_n - 1);
  end

  // Steer the current segment of the held word onto the beat
  always_comb begin
    out_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (int'(seg_cnt) == k) begin
        out_data = {hold_mask[k*BEAT_ATOMS +: BEAT_ATOMS], hold_data[k*BEAT_W +: BEAT_W]};
      end
    end
  end

  // Holding-word valid, mask and segment counter
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      hold_vld  <= 1'b0;
      hold_mask <= '0;
      seg_cnt   <= '0;
    end else if (in_load) begin
      hold_vld  <= 1'b1;
      hold_mask <= inp_mask;
      seg_cnt   <= '0;
    end else if (is_last) begin
      hold_vld  <= 1'b0;
      seg_cnt   <= '0;
    end else if (out_fire) begin
      seg_cnt   <= seg_cnt + 1'b1;
    end
  end

  // Atom payload travels with the mask and is never reset
  always_ff @(posedge nvdla_core_clk) begin
    if (in_load) begin
      hold_data <= inp_data[ATOMS*ATOM_W-1:0];
    end
  end

  // Accepted masks must be contiguous from bit 0
  assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    in_fire |-> mask_is_contig(32'(inp_mask)));

  // Only width ratios 1, 2 and 4 are supported
  assert property (@(posedge nvdla_core_clk) ratio_is_legal(RATIO));

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_pack.sv
// Bench for the SDP write-path packer: directed RATIO 1/2/4 cases plus a
// randomized RATIO=2 run against a word-to-beat reference queue.
module tb_nv_nvdla_sdp_wdma_pack;

  localparam int AW = 256;
  localparam int NA = 4;
  localparam int IW = NA * AW + NA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // RATIO=2 instance
  logic          in_vld, in_rdy, o_vld, o_rdy, o_last;
  logic [IW-1:0] in_data;
  logic [2*AW+1:0] o_data;
  // RATIO=4 instance
  logic          in4_vld, in4_rdy, o4_vld, o4_last;
  logic [IW-1:0] in4_data;
  logic [AW:0]   o4_data;
  // RATIO=1 instance
  logic          in1_vld, in1_rdy, o1_vld, o1_last;
  logic [IW-1:0] in1_data;
  logic [IW-1:0] o1_data;

  nv_nvdla_sdp_wdma_pack #(.RATIO(2)) u_r2 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .inp_pvld(in_vld), .inp_prdy(in_rdy), .inp_data(in_data),
    .out_pvld(o_vld), .out_prdy(o_rdy), .out_data(o_data), .out_last(o_last));

  nv_nvdla_sdp_wdma_pack #(.RATIO(4)) u_r4 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .inp_pvld(in4_vld), .inp_prdy(in4_rdy), .inp_data(in4_data),
    .out_pvld(o4_vld), .out_prdy(1'b1), .out_data(o4_data), .out_last(o4_last));

  nv_nvdla_sdp_wdma_pack #(.RATIO(1)) u_r1 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .inp_pvld(in1_vld), .inp_prdy(in1_rdy), .inp_data(in1_data),
    .out_pvld(o1_vld), .out_prdy(1'b1), .out_data(o1_data), .out_last(o1_last));

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand256();
    logic [AW-1:0] v;
    for (int i = 0; i < AW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [IW-1:0] mkw(input logic [NA-1:0] m, input logic [AW-1:0] a0,
                                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                        input logic [AW-1:0] a3);
    return {m, a3, a2, a1, a0};
  endfunction

  // Reference model: a word with k valid atoms yields ceil(k/2) two-atom beats
  typedef struct {
    logic [1:0]    m;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    cyc = 0;

  function automatic void model_push(input logic [IW-1:0] w);
    logic [NA-1:0] m;
    int ones, nb;
    beat_t b;
    m = w[IW-1 -: NA];
    ones = 0;
    for (int i = 0; i < NA; i++) if (m[i]) ones++;
    nb = (ones + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      b.m    = m[2*k +: 2];
      b.a0   = w[(2*k)*AW +: AW];
      b.a1   = w[(2*k+1)*AW +: AW];
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Monitor on the RATIO=2 instance, sampling on the falling edge
  logic [2*AW+1:0] stall_data;
  logic            stall_last;
  bit              stalled = 0;

  initial forever begin
    beat_t e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      stalled = 0;
    end else begin
      if (stalled && o_vld) begin
        check("stall_lo", o_data[AW-1:0], stall_data[AW-1:0]);
        check("stall_hi", o_data[2*AW-1:AW], stall_data[2*AW-1:AW]);
        check("stall_ml", {o_data[2*AW+1:2*AW], o_last}, {stall_data[2*AW+1:2*AW], stall_last});
      end
      if (o_vld && !(o_rdy && o_last)) check("prdy_busy", in_rdy, 0);
      if (!o_vld) check("prdy_idle", in_rdy, 1);
      if (o_vld && o_rdy) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("extra_beat", o_vld, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_mask", o_data[2*AW+1:2*AW], e.m);
          if (e.m[0]) check("beat_a0", o_data[AW-1:0], e.a0);
          if (e.m[1]) check("beat_a1", o_data[2*AW-1:AW], e.a1);
          check("beat_last", o_last, e.last);
        end
      end
      stalled    = o_vld && !o_rdy;
      stall_data = o_data;
      stall_last = o_last;
      if (in_vld && in_rdy) model_push(in_data);
    end
  end

  // Random back-pressure when enabled
  bit rnd_bp = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_bp) o_rdy = ($urandom_range(0, 3) != 0);
  end

  // Present a word to the RATIO=2 instance and hold it until accepted
  task automatic send(input logic [IW-1:0] w, output int waited);
    in_data = w;
    in_vld  = 1'b1;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_rdy && waited < 200);
    if (!in_rdy) check("accept_timeout", in_rdy, 1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    idle(1);
  endtask

  logic [AW-1:0] a0, a1, a2, a3;
  int            w;

  initial begin
    rst = 1'b1;
    in_vld = 0; in4_vld = 0; in1_vld = 0; o_rdy = 1'b1;
    in_data = '0; in4_data = '0; in1_data = '0;
    a0 = rand256(); a1 = rand256(); a2 = rand256(); a3 = rand256();

    // Reset state on all three instances
    @(negedge clk);
    @(negedge clk);
    check("rst_vld2", o_vld, 0);
    check("rst_rdy2", in_rdy, 1);
    check("rst_mask2", o_data[2*AW+1:2*AW], 0);
    check("rst_last2", o_last, 0);
    check("rst_vld4", o4_vld, 0);
    check("rst_rdy4", in4_rdy, 1);
    check("rst_vld1", o1_vld, 0);
    check("rst_mask1", o1_data[IW-1 -: NA], 0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Two full words back to back: four beats with no bubble
    beat_cyc.delete();
    send(mkw(4'hF, a0, a1, a2, a3), w);
    send(mkw(4'hF, a3, a2, a1, a0), w);
    drain();
    check("full_beats", beat_cyc.size(), 4);
    if (beat_cyc.size() == 4) check("no_bubble", beat_cyc[3] - beat_cyc[0], 3);

    // Partial masks 7 and 1: two beats then one
    beat_cyc.delete();
    send(mkw(4'h7, a0, a1, a2, a3), w);
    send(mkw(4'h1, a2, a3, a0, a1), w);
    drain();
    check("part_beats", beat_cyc.size(), 3);

    // Zero-mask word sandwiched between two full words
    beat_cyc.delete();
    send(mkw(4'hF, a0, a1, a2, a3), w);
    send(mkw(4'h0, a1, a1, a1, a1), w);
    send(mkw(4'hF, a2, a3, a0, a1), w);
    check("zero_next_wait", w, 1);
    drain();
    check("zero_beats", beat_cyc.size(), 4);

    // RATIO=4, mask 3: two single-atom beats
    in4_data = mkw(4'h3, a0, a1, a2, a3);
    in4_vld  = 1'b1;
    @(negedge clk);
    check("r4_rdy", in4_rdy, 1);
    idle(1);
    in4_vld = 1'b0;
    @(negedge clk);
    check("r4_b0_vld", o4_vld, 1);
    check("r4_b0_mask", o4_data[AW], 1);
    check("r4_b0_atom", o4_data[AW-1:0], a0);
    check("r4_b0_last", o4_last, 0);
    @(negedge clk);
    check("r4_b1_vld", o4_vld, 1);
    check("r4_b1_mask", o4_data[AW], 1);
    check("r4_b1_atom", o4_data[AW-1:0], a1);
    check("r4_b1_last", o4_last, 1);
    @(negedge clk);
    check("r4_done", o4_vld, 0);
    idle(1);

    // RATIO=1, mask 7: one beat carrying the whole word
    in1_data = mkw(4'h7, a0, a1, a2, a3);
    in1_vld  = 1'b1;
    @(negedge clk);
    check("r1_rdy", in1_rdy, 1);
    idle(1);
    in1_vld = 1'b0;
    @(negedge clk);
    check("r1_vld", o1_vld, 1);
    check("r1_mask", o1_data[IW-1 -: NA], 4'h7);
    check("r1_a0", o1_data[0 +: AW], a0);
    check("r1_a1", o1_data[AW +: AW], a1);
    check("r1_a2", o1_data[2*AW +: AW], a2);
    check("r1_last", o1_last, 1);
    @(negedge clk);
    check("r1_done", o1_vld, 0);
    idle(1);

    // Randomized legal words under random back-pressure
    rnd_bp = 1;
    for (int n = 0; n < 1000; n++) begin
      logic [NA-1:0] m;
      m = NA'((1 << $urandom_range(0, 4)) - 1);
      send(mkw(m, rand256(), rand256(), rand256(), rand256()), w);
      idle($urandom_range(0, 1));
    end
    drain();
    rnd_bp = 0;
    o_rdy  = 1'b1;
    idle(2);

    // Reset after beat 0 of a full word discards the rest of it
    send(mkw(4'hF, a0, a1, a2, a3), w);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", o_vld, 0);
    check("mid_rst_rdy", in_rdy, 1);
    check("mid_rst_mask", o_data[2*AW+1:2*AW], 0);
    idle(1);
    rst = 1'b0;
    idle(2);
    check("post_rst_idle", o_vld, 0);
    beat_cyc.delete();
    send(mkw(4'hF, a3, a2, a1, a0), w);
    drain();
    check("post_rst_beats", beat_cyc.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
